// File: rtl/nrzi_rx_deframer_if.sv
// nrzi_rx_deframer_if: line-side inputs and byte-side outputs of the NRZI receive deframer.
interface nrzi_rx_deframer_if;
  logic in;
  logic bit_en;
  logic rx_active;
  logic [7:0] data_out;
  logic data_valid;
  logic in_frame;
  logic stuff_err;
  modport master (output in, bit_en, rx_active, input data_out, data_valid, in_frame, stuff_err);
  modport slave (input in, bit_en, rx_active, output data_out, data_valid, in_frame, stuff_err);
endinterface

// File: rtl/nrzi_rx_deframer.sv
// nrzi_rx_deframer: NRZI decode, sync hunt, zero-unstuffing and LSB-first byte assembly.
module nrzi_rx_deframer #(
  parameter logic [7:0] SYNC_PATTERN = 8'h80,
  parameter int STUFF_LEN = 6
) (
  input logic clk,
  input logic areset,
  nrzi_rx_deframer_if.slave bus
);
  typedef enum logic {HUNT, DATA} state_t;
  localparam logic [2:0] STUFF = 3'(STUFF_LEN);
  state_t state;
  logic prev_line;
  logic [7:0] window, shift_reg;
  logic [2:0] ones_cnt, bit_cnt;
  logic dbit;
  logic [7:0] win_nxt, byte_nxt;
  assign dbit = bus.in == prev_line;
  assign win_nxt = {dbit, window[7:1]};
  assign byte_nxt = {dbit, shift_reg[7:1]};
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      state <= HUNT;
      prev_line <= 1'b1;
      window <= '0;
      shift_reg <= '0;
      ones_cnt <= '0;
      bit_cnt <= '0;
      bus.data_out <= '0;
      bus.data_valid <= 1'b0;
      bus.in_frame <= 1'b0;
      bus.stuff_err <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      bus.stuff_err <= 1'b0;
      if (!bus.rx_active) begin
        state <= HUNT;
        bus.in_frame <= 1'b0;
        prev_line <= 1'b1;
        window <= '0;
        shift_reg <= '0;
        ones_cnt <= '0;
        bit_cnt <= '0;
      end else if (bus.bit_en) begin
        prev_line <= bus.in;
        if (state == HUNT) begin
          window <= win_nxt;
          if (win_nxt == SYNC_PATTERN) begin
            state <= DATA;
            bus.in_frame <= 1'b1;
            bit_cnt <= '0;
            ones_cnt <= 3'd1;
          end
        end else if (ones_cnt == STUFF) begin
          // a 1 where a stuffed 0 was required kills the frame
          if (dbit) begin
            bus.stuff_err <= 1'b1;
            state <= HUNT;
            bus.in_frame <= 1'b0;
            window <= '0;
            shift_reg <= '0;
            ones_cnt <= '0;
            bit_cnt <= '0;
          end else
            ones_cnt <= '0;
        end else begin
          shift_reg <= byte_nxt;
          ones_cnt <= dbit ? ones_cnt + 3'd1 : 3'd0;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            bus.data_out <= byte_nxt;
            bus.data_valid <= 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_nrzi_rx_deframer.sv
// tb_nrzi_rx_deframer: NRZI line stimulus checked every cycle against a queue-based reference model.
module tb_nrzi_rx_deframer;
  logic clk = 1'b0;
  logic areset = 1'b1;
  nrzi_rx_deframer_if bus ();
  nrzi_rx_deframer dut (.clk(clk), .areset(areset), .bus(bus));
  always #5 clk = ~clk;
  int errors = 0, checks = 0, n_dv = 0, n_se = 0, gap_max = 0, tx_run = 0;
  logic lvl = 1'b1;
  logic [7:0] e_dout = 8'h00;
  logic e_dv = 0, e_frm = 0, e_se = 0;
  bit m_prev = 1, m_sync = 0, d;
  bit [7:0] hist = 0;
  int run = 0;
  bit acc[$];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: decode from the line, find sync in the last 8 bits, collect accepted bits in a queue
  always @(posedge clk or posedge areset) begin
    if (areset) begin
      m_prev = 1; m_sync = 0; hist = 0; run = 0; acc.delete();
      e_dout = 0; e_dv = 0; e_frm = 0; e_se = 0;
    end else begin
      e_dv = 0; e_se = 0;
      if (!bus.rx_active) begin
        m_prev = 1; m_sync = 0; hist = 0; acc.delete(); e_frm = 0;
      end else if (bus.bit_en) begin
        d = (bus.in == m_prev);
        m_prev = bus.in;
        if (!m_sync) begin
          hist = {d, hist[7:1]};
          if (hist == 8'h80) begin m_sync = 1; run = 1; acc.delete(); end
        end else if (run == 6) begin
          if (d) begin e_se = 1; m_sync = 0; hist = 0; acc.delete(); end
          else run = 0;
        end else begin
          acc.push_back(d);
          run = d ? run + 1 : 0;
          if (acc.size() == 8) begin
            for (int i = 0; i < 8; i++) e_dout[i] = acc[i];
            e_dv = 1;
            acc.delete();
          end
        end
        e_frm = m_sync;
      end
    end
  end
  always @(negedge clk) begin
    chk("data_out", bus.data_out, e_dout);
    chk("data_valid", bus.data_valid, e_dv);
    chk("in_frame", bus.in_frame, e_frm);
    chk("stuff_err", bus.stuff_err, e_se);
    if (bus.data_valid) n_dv++;
    if (bus.stuff_err) n_se++;
  end
  task automatic strobe(bit b);
    int g = $urandom_range(0, gap_max);
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      bus.bit_en = 0;
      bus.in = 1'($urandom);
    end
    @(negedge clk);
    lvl = b ? lvl : ~lvl;
    bus.in = lvl;
    bus.bit_en = 1;
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.bit_en = 0;
      bus.in = lvl;
    end
  endtask
  task automatic send_raw(logic [31:0] bits, int n);
    for (int i = 0; i < n; i++) strobe(bits[i]);
  endtask
  task automatic send_sync();
    send_raw(32'h80, 8);
    tx_run = 1;
  endtask
  task automatic send_byte(logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      strobe(b[i]);
      tx_run = b[i] ? tx_run + 1 : 0;
      if (tx_run == 6) begin strobe(0); tx_run = 0; end
    end
  endtask
  task automatic abort();
    @(negedge clk);
    bus.rx_active = 0;
    bus.bit_en = 0;
    lvl = 1;
    bus.in = 1;
    @(negedge clk);
    bus.rx_active = 1;
  endtask
  task automatic clr();
    n_dv = 0;
    n_se = 0;
  endtask
  initial begin
    bus.in = 1; bus.bit_en = 0; bus.rx_active = 1;
    #12 areset = 0;
    chk("reset_data_out", bus.data_out, 8'h00);
    chk("reset_in_frame", bus.in_frame, 0);
    // basic byte
    clr(); send_sync(); send_byte(8'hA5); idle(3);
    chk("t1_data", bus.data_out, 8'hA5); chk("t1_dv_count", n_dv, 1); chk("t1_in_frame", bus.in_frame, 1);
    // unstuffing: 1 1 1 1 1 0(stuffed) 1 0 0
    abort(); clr(); send_sync(); send_raw(32'h05F, 9); idle(3);
    chk("t2_data", bus.data_out, 8'h3F); chk("t2_dv_count", n_dv, 1); chk("t2_se_count", n_se, 0);
    // stuff violation
    abort(); clr(); send_sync(); send_raw(32'h3F, 6); idle(3);
    chk("t3_se_count", n_se, 1); chk("t3_in_frame", bus.in_frame, 0); chk("t3_dv_count", n_dv, 0);
    clr(); send_sync(); send_byte(8'h5A); idle(3);
    chk("t3_data", bus.data_out, 8'h5A); chk("t3_dv_count2", n_dv, 1);
    // abort mid-byte
    clr(); abort(); send_sync(); send_raw(32'hB, 4); abort(); idle(2);
    chk("t4_in_frame", bus.in_frame, 0); chk("t4_dv_count", n_dv, 0); chk("t4_data_held", bus.data_out, 8'h5A);
    send_sync(); send_byte(8'hC3); idle(3);
    chk("t4_data", bus.data_out, 8'hC3); chk("t4_dv_count2", n_dv, 1);
    // strobe every 4th cycle with junk on the line in between
    abort(); clr(); gap_max = 3;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 3; k++) begin @(negedge clk); bus.bit_en = 0; bus.in = ~bus.in; end
      @(negedge clk); lvl = i == 7 ? lvl : ~lvl; bus.in = lvl; bus.bit_en = 1;
    end
    tx_run = 1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 3; k++) begin @(negedge clk); bus.bit_en = 0; bus.in = ~bus.in; end
      @(negedge clk); lvl = (8'hA5 >> i) & 1 ? lvl : ~lvl; bus.in = lvl; bus.bit_en = 1;
    end
    idle(4);
    chk("t5_data", bus.data_out, 8'hA5); chk("t5_dv_count", n_dv, 1);
    gap_max = 0;
    // async reset between edges
    abort(); send_sync(); send_raw(32'h6, 4);
    @(posedge clk); #2 areset = 1; #1;
    chk("t6_data_out", bus.data_out, 8'h00); chk("t6_in_frame", bus.in_frame, 0);
    chk("t6_dv", bus.data_valid, 0); chk("t6_se", bus.stuff_err, 0);
    @(negedge clk); areset = 0; lvl = 1; bus.in = 1; bus.bit_en = 0;
    clr(); send_sync(); send_byte(8'h01); idle(3);
    chk("t6_data", bus.data_out, 8'h01); chk("t6_dv_count", n_dv, 1);
    // randomized traffic, checked by the model every cycle
    for (int it = 0; it < 60; it++) begin
      int r = $urandom_range(0, 9);
      gap_max = $urandom_range(0, 2);
      if (r < 6) begin
        send_sync();
        for (int k = 0, nb = $urandom_range(1, 3); k < nb; k++) send_byte(8'($urandom));
      end else if (r < 8) send_raw($urandom, 16);
      else abort();
      idle($urandom_range(0, 3));
    end
    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
